// File: rtl/systolic_deskew_collector_if.sv
// Result-row handshake between the deskew collector and its consumer.
//
// Handshake: a row transfers on a rising clock edge where out_valid and
// out_ready are both 1. The producer holds out_data/out_row/out_last stable
// while out_valid=1 and the row has not yet been accepted. out_ready may be
// driven at any time and does not depend on out_valid.
//
// Signals:
//   out_valid  producer -> consumer  aligned row held in the output register
//   out_ready  consumer -> producer  consumer accepts the row this cycle
//   out_data   producer -> consumer  DIM*BITS, column j at [j*BITS +: BITS]
//   out_row    producer -> consumer  row index of out_data
//   out_last   producer -> consumer  out_row == DIM-1
interface systolic_deskew_collector_if #(
    parameter int DIM  = 8,
    parameter int BITS = 32
);
    logic                    out_valid;
    logic                    out_ready;
    logic [DIM*BITS-1:0]     out_data;
    logic [$clog2(DIM)-1:0]  out_row;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic_deskew_collector.sv
// Re-aligns the time-skewed result rows of a DIM x DIM systolic array.
// Column j of a row leaves the array j enable-cycles after column 0, so
// column j is delayed by DIM-1-j enable-cycles to line the whole row up.
// Each aligned row is registered and offered on a valid/ready interface;
// hold asks upstream to freeze the array while a row is stuck in the output
// register. A row captured over an unaccepted one overwrites it and sets
// the sticky err flag.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       pulse marking the en-cycle with column 0 of row 0 (IDLE only)
//   en          array advance enable; delay lines and counter move only on en
//   col_data    skewed array outputs, column j at [j*BITS +: BITS]
//   result      master side of the row handshake interface
//   busy        collection in progress (state != IDLE)
//   hold        request upstream to drop en
//   err         sticky overflow flag
//   state_dbg   current FSM state
module systolic_deskew_collector #(
    parameter int DIM  = 8,
    parameter int BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     en,
    input  logic [DIM*BITS-1:0]      col_data,
    systolic_deskew_collector_if.master result,
    output logic                     busy,
    output logic                     hold,
    output logic                     err,
    output logic [1:0]               state_dbg
);
    localparam int KW = $clog2(2*DIM);
    localparam int RW = $clog2(DIM);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [KW-1:0] K_FILL_END  = KW'(DIM-2);
    localparam logic [KW-1:0] K_FIRST_ROW = KW'(DIM-1);
    localparam logic [KW-1:0] K_LAST      = KW'(2*DIM-2);

    logic [1:0]          state;
    logic [KW-1:0]       k;
    logic [DIM*BITS-1:0] aligned;
    logic                capture;
    logic [KW-1:0]       row_k;

    logic                valid_q;
    logic [DIM*BITS-1:0] data_q;
    logic [RW-1:0]       row_q;
    logic                last_q;
    logic                err_q;

    // Last column needs no delay.
    assign aligned[(DIM-1)*BITS +: BITS] = col_data[(DIM-1)*BITS +: BITS];

    for (genvar j = 0; j < DIM-1; j++) begin : g_col
        localparam int DEPTH = DIM-1-j;
        logic [BITS-1:0] stage [DEPTH];

        // Shifts on every en-cycle regardless of FSM state, so the line is
        // already primed with the right history when a collection starts.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
            end else if (en) begin
                stage[0] <= col_data[j*BITS +: BITS];
                for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
            end
        end

        assign aligned[j*BITS +: BITS] = stage[DEPTH-1];
    end

    assign capture = (state == DRAIN) && en;
    assign row_k   = k - K_FIRST_ROW;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The start cycle is k=0; it only counts if en is high.
                    if (start) begin
                        k     <= en ? KW'(1) : '0;
                        state <= (en && K_FILL_END == '0) ? DRAIN : FILL;
                    end
                end
                FILL: begin
                    if (en) begin
                        k <= k + KW'(1);
                        if (k == K_FILL_END) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (en) begin
                        if (k == K_LAST) begin
                            state <= IDLE;
                            k     <= '0;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    k     <= '0;
                end
            endcase
        end
    end

    // A capture wins over an accept on the same edge: the new row loads
    // and valid stays high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (capture) begin
            data_q  <= aligned;
            row_q   <= row_k[RW-1:0];
            last_q  <= (row_k == KW'(DIM-1));
            valid_q <= 1'b1;
            if (valid_q && !result.out_ready) err_q <= 1'b1;
        end else if (result.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign result.out_valid = valid_q;
    assign result.out_data  = data_q;
    assign result.out_row   = row_q;
    assign result.out_last  = last_q;

    assign busy      = (state != IDLE);
    assign hold      = (state == DRAIN) && valid_q && !result.out_ready;
    assign err       = err_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_systolic_deskew_collector.sv
// Bench for systolic_deskew_collector (DIM=4, BITS=8). The reference model
// works on whole matrices: rows are known up front, col_data is generated
// from the skew rule, and expected rows come straight from the matrix.
module tb_systolic_deskew_collector;
    localparam int DIM  = 4;
    localparam int BITS = 8;
    localparam int W    = DIM*BITS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  col_data = '0;
    logic          busy;
    logic          hold;
    logic          err;
    logic [1:0]    state_dbg;

    systolic_deskew_collector_if #(.DIM(DIM), .BITS(BITS)) res_if ();

    systolic_deskew_collector #(.DIM(DIM), .BITS(BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .en        (en),
        .col_data  (col_data),
        .result    (res_if),
        .busy      (busy),
        .hold      (hold),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [BITS-1:0] mat [DIM][DIM];
    logic [W-1:0] exp_q[$];      // rows captured but not yet accepted
    int           row_q[$];
    int           acc_q[$];      // row indices accepted by the consumer
    int           want_acc[$];
    bit           m_known = 1'b0;
    bit           m_active = 1'b0;
    bit           m_err = 1'b0;
    int           m_k = 0;
    logic [W-1:0] m_data = '0;
    int           m_row = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] row_word(input int r);
        logic [W-1:0] w;
        for (int j = 0; j < DIM; j++) w[j*BITS +: BITS] = mat[r][j];
        return w;
    endfunction

    // Column j carries row kk-j at en-cycle kk; anything else is noise.
    function automatic logic [W-1:0] col_word(input int kk);
        logic [W-1:0] w;
        for (int j = 0; j < DIM; j++) begin
            if (kk - j >= 0 && kk - j < DIM) w[j*BITS +: BITS] = mat[kk-j][j];
            else w[j*BITS +: BITS] = BITS'($urandom);
        end
        return w;
    endfunction

    function automatic logic [W-1:0] junk_word();
        logic [W-1:0] w;
        for (int j = 0; j < DIM; j++) w[j*BITS +: BITS] = BITS'($urandom);
        return w;
    endfunction

    function automatic bit hold_m(input bit rdy);
        return m_active && (m_k >= DIM-1) && (exp_q.size() != 0) && !rdy;
    endfunction

    task automatic set_mat_seq(input int base);
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) mat[r][j] = BITS'(base + 16*r + j);
    endtask

    task automatic set_mat_rand();
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) mat[r][j] = BITS'($urandom);
    endtask

    // ---------------- driver ----------------
    // Drive one cycle, check outputs at the falling edge, then advance the
    // model with the inputs the DUT sampled at the rising edge.
    task automatic step(input bit st, input bit e, input bit rdy, input bit rs);
        rst_n = rs;
        start = st;
        en = e;
        res_if.out_ready = rdy;
        if (!rs) col_data = '1;
        else if (m_active) col_data = col_word(m_k);
        else if (st) col_data = col_word(0);
        else col_data = junk_word();

        @(negedge clk);
        if (m_known) begin
            check("out_valid", res_if.out_valid, exp_q.size() != 0);
            check("out_data", res_if.out_data, m_data);
            check("out_row", res_if.out_row, m_row);
            check("out_last", res_if.out_last, m_row == DIM-1);
            check("busy", busy, m_active);
            check("hold", hold, hold_m(rdy));
            check("err", err, m_err);
            if (rdy && exp_q.size() != 0) check("accept_data", res_if.out_data, exp_q[0]);
        end

        @(posedge clk);
        if (!rs) begin
            m_known = 1'b1;
            m_active = 1'b0;
            m_k = 0;
            m_err = 1'b0;
            exp_q.delete();
            row_q.delete();
            m_data = '0;
            m_row = 0;
        end else begin
            if (rdy && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                acc_q.push_back(row_q.pop_front());
            end
            if (m_active) begin
                if (e) begin
                    if (m_k >= DIM-1) begin
                        if (exp_q.size() != 0) begin
                            m_err = 1'b1;
                            exp_q.delete();
                            row_q.delete();
                        end
                        m_row = m_k - (DIM-1);
                        m_data = row_word(m_row);
                        exp_q.push_back(m_data);
                        row_q.push_back(m_row);
                    end
                    if (m_k == 2*DIM-2) begin
                        m_active = 1'b0;
                        m_k = 0;
                    end else begin
                        m_k++;
                    end
                end
            end else if (st) begin
                m_active = 1'b1;
                m_k = e ? 1 : 0;
            end
        end
        #1;
    endtask

    task automatic want_all_rows();
        want_acc.delete();
        for (int r = 0; r < DIM; r++) want_acc.push_back(r);
    endtask

    task automatic check_acc(input string tag);
        check({tag, "_count"}, acc_q.size(), want_acc.size());
        for (int i = 0; i < acc_q.size() && i < want_acc.size(); i++)
            check({tag, "_row"}, acc_q[i], want_acc[i]);
        acc_q.delete();
        want_acc.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g2;
        int g4;
        int held;
        bit rdy;
        bit e;
        bit obey;

        @(posedge clk);
        #1;

        // Reset with all-ones on the array and en high.
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_valid", res_if.out_valid, 0);
        check("rst_data", res_if.out_data, 0);
        check("rst_row", res_if.out_row, 0);
        check("rst_last", res_if.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_hold", hold, 0);
        check("rst_err", err, 0);

        // Basic de-skew, continuous en and ready.
        set_mat_seq(0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b1);
        want_all_rows();
        check_acc("basic");

        // en gaps of two cycles at k=2 and k=4.
        set_mat_seq(0);
        g2 = 2;
        g4 = 2;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 14; c++) begin
            e = 1'b1;
            if (m_active && m_k == 2 && g2 > 0) begin e = 1'b0; g2--; end
            else if (m_active && m_k == 4 && g4 > 0) begin e = 1'b0; g4--; end
            step(1'b0, e, 1'b1, 1'b1);
        end
        want_all_rows();
        check_acc("gaps");

        // Backpressure after row 1 capture; upstream obeys hold.
        set_mat_seq(0);
        held = 0;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            rdy = 1'b1;
            if (m_active && m_k == DIM+1 && held < 3) begin rdy = 1'b0; held++; end
            e = !hold_m(rdy);
            step(1'b0, e, rdy, 1'b1);
        end
        check("bp_held_cycles", held, 3);
        want_all_rows();
        check_acc("bp");

        // Overflow: ready drops after row 1 capture, en ignores hold.
        set_mat_seq(0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("ovf_data", res_if.out_data, 32'h23222120);
        check("ovf_err", err, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("ovf_err_sticky", err, 1);
        want_acc.delete();
        want_acc.push_back(0);
        want_acc.push_back(DIM-1);
        check_acc("ovf");

        // Reset at k=4, then a fresh collection with base 0x40.
        set_mat_seq(0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 10 && m_k < 4; c++) step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("mrst_valid", res_if.out_valid, 0);
        check("mrst_busy", busy, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        acc_q.delete();
        set_mat_seq(8'h40);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b1);
        want_all_rows();
        check_acc("mrst");

        // Randomized collections: random en/ready, stray starts while busy.
        for (int n = 0; n < 10; n++) begin
            obey = ($urandom_range(0, 1) == 1);
            set_mat_rand();
            repeat ($urandom_range(0, 3))
                step(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
            step(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
            for (int c = 0; c < 200 && m_active; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                e = ($urandom_range(0, 3) != 0);
                if (obey && hold_m(rdy)) e = 1'b0;
                step($urandom_range(0, 7) == 0, e, rdy, 1'b1);
            end
            check("rand_done", busy, 0);
        end
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/systolic_deskew_collector.md
Name: systolic_deskew_collector

Overview:
Output-side counterpart to the input skew delay buffers of the matrix multiplier. The systolic array emits result rows skewed in time: column j of row r appears one enable-cycle after column j-1. This block re-aligns each row with per-column delay lines of decreasing depth. It presents each complete row on a valid/ready interface and raises a hold request so upstream freezes the array (drops en) under backpressure.

Parameters:
DIM, 8, array dimension: number of columns and number of rows per collection
BITS, 32, width of one result element

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
start  input  1  pulse; marks the en-cycle where column 0 of row 0 is on col_data; sampled only in IDLE
en  input  1  array advance enable; delay lines and cycle counter advance only when en=1
col_data  input  DIM*BITS  array outputs; column j at bits [j*BITS +: BITS]
out_valid  output  1  aligned row held in output register
out_ready  input  1  consumer accepts row when out_valid & out_ready
out_data  output  DIM*BITS  aligned row, column j at [j*BITS +: BITS]
out_row  output  $clog2(DIM)  row index of out_data
out_last  output  1  out_row == DIM-1
busy  output  1  state != IDLE
hold  output  1  request upstream to drop en
err  output  1  sticky overflow flag

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, counter k=0, all delay-line stages 0, out_valid=0, out_data=0, out_row=0, out_last=0, hold=0, err=0. Reset mid-collection aborts it; a pending output row is discarded.
- Delay lines: column j has depth DIM-1-j and shifts when en=1 in any state. Column DIM-1 has depth 0 and is a wire. The aligned word for column j equals col_data[j] from DIM-1-j en-cycles earlier.
- Counter k counts en-cycles: k=0 on the start cycle, and k increments at each posedge with en=1 while busy.
- FSM:
  - IDLE: start=1 moves to FILL. The start cycle is k=0 and is counted only if en=1. If en=0 with start, FSM still moves to FILL at k=0, and the first en cycle is k=0.
  - FILL: k < DIM-1; no capture. Moves to DRAIN on the en-cycle with k=DIM-2.
  - DRAIN: k in DIM-1 .. 2*DIM-2. Each en-cycle captures the aligned row r=k-(DIM-1) at the posedge: out_data/out_row/out_last load, out_valid=1. After capturing row DIM-1, moves to IDLE.
- start outside IDLE is ignored.
- Output handshake: out_valid falls on the posedge where out_ready=1, unless a new capture occurs on the same edge. Simultaneous accept and capture loads the new row with out_valid=1. Output is registered with 1-cycle latency after the aligned en-cycle.
- hold = (state==DRAIN) & out_valid & ~out_ready, combinational.
- Overflow: if a capture occurs while out_valid & ~out_ready, the new row overwrites the old one and err is set. err stays set until reset.
- A pending last row may remain valid in IDLE. A new start is legal then, since the first capture is at least DIM-1 en-cycles away.
- Total latency: row r is valid one cycle after en-cycle r+DIM-1. A collection spans 2*DIM-1 en-cycles.

Test Plan:
- Reset values: DIM=4, BITS=8. Drive col_data=all 0xFF with en=1 and rst_n=0 for 3 cycles, then rst_n=1. Required: all outputs 0 and delay stages 0 (first capture after start shows only new data).
- Basic de-skew: DIM=4, BITS=8, out_ready=1, en=1 continuous. Column j of row r is driven at k=r+j with value 16r+j, 0 otherwise. Required: out_data=0x03020100, 0x13121110, 0x23222120, 0x33323130 on consecutive cycles after k=3..6; out_last only on row 3; busy falls after k=6.
- en gaps: same stimulus with en=0 inserted for 2 cycles at k=2 and k=4, col_data held. Required: identical rows, each delayed by stalled cycles; no duplicate or skipped rows.
- Backpressure: out_ready=0 from row 1 capture onward. Required: hold=1 while row 1 is pending. Driving en=0 while hold=1 keeps state and delay lines frozen. Releasing out_ready for 1 cycle accepts row 1, then rows 2 and 3 follow. err=0.
- Overflow: out_ready=0 and en kept 1 despite hold. Required: err=1 after row 2 capture, out_data=0x23222120; err stays 1 after out_ready=1.
- Mid-run reset and restart: rst_n=0 at k=4, then start with row value base 0x40. Required: out_valid=0 during reset; next rows contain 0x4x values only, with no stale data.
